// File: rtl/mem_access_pkg.sv
// Shared constants and types for the CPU data-RAM access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_access_pkg;

  // Access size encoding, identical to the RAM Mode input.
  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_DBYTE = 2'b01;
  localparam logic [1:0] MODE_WORD  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Sign/zero extension of RAM read data to 32 bits according to access size.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (RAM data, byte/half in low bits), size (Mode encoding),
//        is_unsigned (1 = zero-extend), ext_data (extended result).
module load_extender
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data
);

  logic fill_b;
  logic fill_h;

  assign fill_b = ~is_unsigned & rdata[7];
  assign fill_h = ~is_unsigned & rdata[15];

  always_comb begin
    ext_data = rdata;
    case (size)
      MODE_BYTE:  ext_data = {{24{fill_b}}, rdata[7:0]};
      MODE_DBYTE: ext_data = {{16{fill_h}}, rdata[15:0]};
      default:    ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the 32-bit data RAM: one load/store at a time, single-cycle response.
// Latency accept->resp_valid: store 2, load RD_LAT+1, error 1 cycle.
// Backpressure: req_ready low whenever not IDLE; producer must hold req_valid.
//
// Ports: clk/clr (sync active-high reset); req_* request channel (valid/ready);
//        resp_valid/resp_rdata/resp_err one-cycle response; ram_* RAM port
//        (addr, mode, mem_write, sel, wdata out; rdata in).
// Config: MEM_ACCESS_ALIGN_CHECK_EN defined -> misaligned half/word are errors;
//         undefined -> low address bits are forced to alignment instead.
//         Size 2'b11 is always an error.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_mode,
  output logic              ram_mem_write,
  output logic              ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t            state;
  logic [2:0]        lat_cnt;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] acc_addr;
  logic              req_err;
  logic [31:0]       ext_data;
  logic              unused_addr_hi;

  // Upper request address bits are deliberately dropped (address wraps).
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  assign req_ready = (state == IDLE);

  // Error check and effective address for the incoming request.
  always_comb begin
    acc_addr = req_addr[ADDR_W-1:0];
    req_err  = (req_size == MODE_RSVD);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (req_size == MODE_DBYTE && req_addr[0])
      req_err = 1'b1;
    if (req_size == MODE_WORD && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
`else
    if (req_size == MODE_DBYTE)
      acc_addr[0] = 1'b0;
    if (req_size == MODE_WORD)
      acc_addr[1:0] = 2'b00;
`endif
  end

  // Extension uses the latched size so the RAM can return raw low-lane data.
  load_extender u_ext (
    .rdata      (ram_rdata),
    .size       (size_q),
    .is_unsigned(uns_q),
    .ext_data   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= IDLE;
      lat_cnt       <= 3'd0;
      size_q        <= MODE_WORD;
      uns_q         <= 1'b0;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= 32'd0;
      ram_sel       <= 1'b0;
      ram_mem_write <= 1'b0;
      ram_addr      <= '0;
      ram_mode      <= MODE_WORD;
      ram_wdata     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          lat_cnt    <= 3'd0;
          if (req_valid) begin
            if (req_err) begin
              // Bad request never touches the RAM pins.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state         <= ACCESS;
              size_q        <= req_size;
              uns_q         <= req_unsigned;
              ram_addr      <= acc_addr;
              ram_mode      <= req_size;
              ram_wdata     <= req_wdata;
              ram_sel       <= 1'b1;
              ram_mem_write <= req_write;
            end
          end
        end
        ACCESS: begin
          if (ram_mem_write) begin
            // Stores occupy exactly one select cycle.
            ram_sel       <= 1'b0;
            ram_mem_write <= 1'b0;
            state         <= RESP;
            resp_valid    <= 1'b1;
          end else if (lat_cnt == LAST_CNT) begin
            // Last hold cycle: capture the extended read data.
            ram_sel    <= 1'b0;
            lat_cnt    <= 3'd0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ext_data;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
